// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bus bundle between the requesting clients, the arbiter and uart_tx.
//
//   Client side handshake: req[i] acts as "valid". The client holds req[i]
//   and its byte data_in[i*DATA_SIZE +: DATA_SIZE] stable until it sees
//   ack[i]. ack[i] is a one-cycle pulse that means the byte has been taken.
//   The client may change req/data in the cycle after ack. Lowering req
//   before ack withdraws the byte, and no ack follows.
//
//   uart_tx side: tx_start is a one-cycle pulse with tx_data valid.
//   tx_data stays stable afterwards. tx_done_tick is a one-cycle pulse
//   from uart_tx when the stop bit ends.
//
//   Signals
//     req           client -> arbiter   per-requester byte valid
//     data_in       client -> arbiter   packed bytes, requester i at slice i
//     ack           arbiter -> client   one-hot byte-taken pulse
//     tx_start      arbiter -> uart_tx  start pulse
//     tx_data       arbiter -> uart_tx  byte to send
//     tx_done_tick  uart_tx -> arbiter  end-of-frame pulse
//
//   Modports
//     master : environment view (clients plus uart_tx)
//     slave  : arbiter view
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8
) ();
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_SIZE-1:0] data_in;
    logic [NUM_REQ-1:0]           ack;
    logic                         tx_start;
    logic [DATA_SIZE-1:0]         tx_data;
    logic                         tx_done_tick;

    modport master (
        output req,
        output data_in,
        output tx_done_tick,
        input  ack,
        input  tx_start,
        input  tx_data
    );

    modport slave (
        input  req,
        input  data_in,
        input  tx_done_tick,
        output ack,
        output tx_start,
        output tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter that shares one uart_tx between NUM_REQ byte sources.
//   The arbiter grants one requester, sends its byte to uart_tx and waits for
//   tx_done_tick. A grantee that keeps requesting holds the grant for up to
//   BURST_MAX back-to-back bytes. After that the grant rotates. A watchdog
//   gives up on a byte when uart_tx never reports done.
//
//   Ports
//     clk          system clock
//     reset_n      asynchronous, active-low reset
//     bus          uart_tx_arbiter_if.slave: req/data_in/ack towards the
//                  clients, tx_start/tx_data/tx_done_tick towards uart_tx
//     grant_id     index of the current or last granted requester
//     busy         high in every state except IDLE
//     timeout_err  one-cycle pulse when the watchdog expires
//     state_dbg    raw FSM state, for observation only
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int BURST_MAX = 16,
    parameter int TIMEOUT   = 16384
) (
    input  logic                       clk,
    input  logic                       reset_n,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [1:0]                 state_dbg
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(BURST_MAX + 1);
    // A disabled watchdog (TIMEOUT == 0) still keeps a 1-bit counter so that
    // the widths stay legal. The counter then never moves.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BC_W-1:0]    BC_MAX  = BC_W'(BURST_MAX);
    localparam logic [WD_W-1:0]    WD_SAT  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]    WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [NUM_REQ-1:0] ONE_REQ = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [BC_W-1:0] burst_cnt;
    logic [WD_W-1:0] wd_cnt;

    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    logic [ID_W-1:0] grant_after;
    logic            wd_expired;

    assign state_dbg = state;

    // The wrap is written out explicitly so that non-power-of-2 NUM_REQ
    // never produces an index past the last requester.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        if (i == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + ID_W'(1);
    endfunction

    // The search starts at rr_ptr, so the requester that finished last has
    // the lowest priority.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
    end

    assign grant_after = wrap_inc(grant_id);
    assign wd_expired  = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bus.ack      <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            wd_cnt       <= '0;
        end else begin
            bus.ack      <= '0;
            bus.tx_start <= 1'b0;
            timeout_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_id  <= pick;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    if (bus.req[grant_id]) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= bus.data_in[grant_id*DATA_SIZE +: DATA_SIZE];
                        bus.ack      <= ONE_REQ << grant_id;
                        wd_cnt       <= '0;
                        burst_cnt    <= burst_cnt + BC_W'(1);
                        state        <= WAIT;
                    end else begin
                        // The requester withdrew between arbitration and load.
                        rr_ptr <= grant_after;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end

                WAIT: begin
                    if (wd_cnt != WD_SAT) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                    // A done tick in the same cycle as the watchdog expiry
                    // takes priority, so a late but valid frame is not
                    // reported as an error.
                    if (bus.tx_done_tick) begin
                        if (bus.req[grant_id] && (burst_cnt < BC_MAX)) begin
                            state <= LOAD;
                        end else begin
                            rr_ptr    <= grant_after;
                            burst_cnt <= '0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= grant_after;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
